// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master arbiter.
// Holds FSM encoding, counter width and the round-robin pick function.
package spi_pkg;

  localparam int SPI_OUTSTANDING_WIDTH = 2;
  localparam int SPI_MAX_REQ = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DRAIN,
    ST_RELEASE
  } arb_state_e;

  // First set bit of req at or above ptr, wrapping modulo n.
  // Walks offsets high to low so the smallest offset wins.
  function automatic logic [SPI_MAX_REQ-1:0] rr_pick(
    input logic [SPI_MAX_REQ-1:0] req,
    input logic [2:0]             ptr,
    input int                     n
  );
    logic [SPI_MAX_REQ-1:0] oh;
    logic [3:0]             idx;
    oh = '0;
    for (int k = SPI_MAX_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(n)) idx = idx - 4'(n);
      if (k < n && req[idx[2:0]]) begin
        oh = '0;
        oh[idx[2:0]] = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/spi_master_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant plus its index.
// Ports: req/ptr in; pick (one-hot), pick_idx, any out.
import spi_pkg::*;

module rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] pick_idx,
  output logic          any
);

  logic [SPI_MAX_REQ-1:0] req_ext;
  logic [SPI_MAX_REQ-1:0] pick_ext;
  logic [2:0]             ptr_ext;

  always_comb begin
    req_ext = '0;
    req_ext[N-1:0] = req;
    ptr_ext = '0;
    ptr_ext[IW-1:0] = ptr;
    pick_ext = rr_pick(req_ext, ptr_ext, N);
    pick = pick_ext[N-1:0];
    any = |pick_ext;
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master between N requesters.
// Ports: req_* / rsp_* client side, m_spi_* / s_spi_* master side, cs gating.
import spi_pkg::*;

module spi_master_arbiter #(
  parameter int NR_REQUESTERS  = 2,
  parameter int SPI_DATA_WIDTH = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NR_REQUESTERS*SPI_DATA_WIDTH-1:0] req_d,
  input  logic [NR_REQUESTERS-1:0]                req_dv,
  input  logic [NR_REQUESTERS-1:0]                req_last,
  output logic [NR_REQUESTERS-1:0]                req_dr,
  output logic [SPI_DATA_WIDTH-1:0]               rsp_d,
  output logic [NR_REQUESTERS-1:0]                rsp_dv,
  output logic [NR_REQUESTERS-1:0]                grant,
  output logic [SPI_DATA_WIDTH-1:0]               m_spi_d,
  output logic                                    m_spi_dv,
  input  logic                                    m_spi_dr,
  input  logic [SPI_DATA_WIDTH-1:0]               s_spi_d,
  input  logic                                    s_spi_dv,
  input  logic                                    spi_cs_n,
  output logic [NR_REQUESTERS-1:0]                slave_cs_n
);

  localparam int N  = NR_REQUESTERS;
  localparam int W  = SPI_DATA_WIDTH;
  localparam int IW = $clog2(N);
  localparam int OW = SPI_OUTSTANDING_WIDTH;

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OW-1:0] outstanding_q, outstanding_d;

  logic [N-1:0]  pick;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          active;
  logic          accept;
  logic          rsp_hit;

  rr_picker #(
    .N  (N),
    .IW (IW)
  ) u_picker (
    .req      (req_dv),
    .ptr      (rr_ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    active   = (state_q == ST_XFER) || (state_q == ST_DRAIN);
    m_spi_d  = '0;
    m_spi_dv = 1'b0;
    req_dr   = '0;
    if (state_q == ST_XFER) begin
      m_spi_d        = req_d[gidx_q*W +: W];
      m_spi_dv       = req_dv[gidx_q];
      req_dr[gidx_q] = m_spi_dr;
    end
    accept = m_spi_dv & m_spi_dr;
    // Stray receive strobes with nothing in flight are dropped.
    rsp_hit = active & s_spi_dv & (outstanding_q != '0);
    rsp_d = active ? s_spi_d : '0;
    rsp_dv = '0;
    rsp_dv[gidx_q] = rsp_hit;
    grant = grant_q;
    slave_cs_n = ~grant_q | {N{spi_cs_n}};
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    rr_ptr_d      = rr_ptr_q;
    outstanding_d = outstanding_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d       = pick;
          gidx_d        = pick_idx;
          outstanding_d = '0;
          state_d       = ST_XFER;
        end
      end
      ST_XFER: begin
        if (accept && !rsp_hit)
          outstanding_d = outstanding_q + 1'b1;
        else if (!accept && rsp_hit)
          outstanding_d = outstanding_q - 1'b1;
        if (accept && req_last[gidx_q])
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (rsp_hit)
          outstanding_d = outstanding_q - 1'b1;
        if (outstanding_q == '0 && spi_cs_n)
          state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        grant_d  = '0;
        rr_ptr_d = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      gidx_q        <= '0;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a loopback spi_master model.
// Checks grant order, response routing, cs gating and reset behaviour.
import spi_pkg::*;

module tb_spi_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req_d;
  logic [1:0]  req_dv, req_last, req_dr;
  logic [7:0]  rsp_d;
  logic [1:0]  rsp_dv, grant, slave_cs_n;
  logic [7:0]  m_spi_d, s_spi_d;
  logic        m_spi_dv, m_spi_dr, s_spi_dv, spi_cs_n;

  int checks = 0;
  int failures = 0;

  spi_master_arbiter #(
    .NR_REQUESTERS  (2),
    .SPI_DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_d      (req_d),
    .req_dv     (req_dv),
    .req_last   (req_last),
    .req_dr     (req_dr),
    .rsp_d      (rsp_d),
    .rsp_dv     (rsp_dv),
    .grant      (grant),
    .m_spi_d    (m_spi_d),
    .m_spi_dv   (m_spi_dv),
    .m_spi_dr   (m_spi_dr),
    .s_spi_d    (s_spi_d),
    .s_spi_dv   (s_spi_dv),
    .spi_cs_n   (spi_cs_n),
    .slave_cs_n (slave_cs_n)
  );

  always #5 clk = ~clk;

  // Loopback spi_master: 4 busy cycles per word, cs low while busy.
  logic       mdl_busy;
  logic [1:0] mdl_cnt;
  logic [7:0] mdl_sh;
  assign m_spi_dr = !mdl_busy;

  always @(posedge clk) begin
    if (rst) begin
      mdl_busy <= 1'b0;
      mdl_cnt  <= '0;
      mdl_sh   <= '0;
      s_spi_dv <= 1'b0;
      s_spi_d  <= '0;
      spi_cs_n <= 1'b1;
    end else begin
      s_spi_dv <= 1'b0;
      if (mdl_busy) begin
        if (mdl_cnt == 0) begin
          mdl_busy <= 1'b0;
          s_spi_dv <= 1'b1;
          s_spi_d  <= mdl_sh;
          spi_cs_n <= 1'b1;
        end else begin
          mdl_cnt <= mdl_cnt - 1'b1;
        end
      end else if (m_spi_dv && m_spi_dr) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= 2'd3;
        mdl_sh   <= m_spi_d;
        spi_cs_n <= 1'b0;
      end
    end
  end

  // Observation logs, sampled on the falling edge.
  int rsp_q[$];
  int gnt_q[$];
  int st_q[$];
  int exp_q[$];
  int cs0_low, cs1_low, viol, first_dr1;
  logic [1:0] grant_prev = '0;
  arb_state_e st_prev = ST_IDLE;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if (rsp_dv[i]) rsp_q.push_back(i * 256 + int'(rsp_d));
    if (grant != 0 && grant != grant_prev) gnt_q.push_back(int'(grant));
    grant_prev = grant;
    if (dut.state_q != st_prev) st_q.push_back(int'(dut.state_q));
    st_prev = dut.state_q;
    if (!slave_cs_n[0]) cs0_low++;
    if (!slave_cs_n[1]) cs1_low++;
    if ((req_dr & ~grant) != 0) viol++;
    if (req_dr[1] && first_dr1 < 0) first_dr1 = rsp_q.size();
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag, input int got[$],
                           input int exp[$]);
    check({tag, "_n"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(tag, got[i], exp[i]);
  endtask

  task automatic clear_logs();
    @(negedge clk);
    #2;
    rsp_q.delete();
    gnt_q.delete();
    st_q.delete();
    cs0_low = 0;
    cs1_low = 0;
    first_dr1 = -1;
  endtask

  task automatic wait_dr(input int r);
    int t;
    t = 0;
    #1;
    while (!req_dr[r] && t < 400) begin
      @(negedge clk);
      #1;
      t++;
    end
    check($sformatf("dr%0d", r), req_dr[r], 1'b1);
  endtask

  task automatic send_txn(input int r, input logic [31:0] words,
                          input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      if (k == 1 && gap > 0) repeat (gap) @(negedge clk);
      req_d[r*8 +: 8] = words[k*8 +: 8];
      req_last[r] = (k == n - 1);
      req_dv[r] = 1'b1;
      wait_dr(r);
      @(negedge clk);
      req_dv[r] = 1'b0;
      req_last[r] = 1'b0;
    end
  endtask

  task automatic wait_release();
    int t;
    t = 0;
    while (grant != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("release", grant, 2'b00);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_d = '0;
    req_dv = '0;
    req_last = '0;
    viol = 0;
    first_dr1 = -1;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 2'b00);
    check("rst_req_dr", req_dr, 2'b00);
    check("rst_rsp_dv", rsp_dv, 2'b00);
    check("rst_rsp_d", rsp_d, 8'h00);
    check("rst_m_dv", m_spi_dv, 1'b0);
    check("rst_m_d", m_spi_d, 8'h00);
    check("rst_cs", slave_cs_n, 2'b11);
    rst = 1'b0;

    // Simultaneous requests from reset, two rounds.
    clear_logs();
    fork
      send_txn(0, 32'h11, 1, 0);
      send_txn(1, 32'h22, 1, 0);
    join
    wait_release();
    fork
      send_txn(0, 32'h33, 1, 0);
      send_txn(1, 32'h44, 1, 0);
    join
    wait_release();
    exp_q = '{1, 2, 1, 2};
    check_log("alt_grant", gnt_q, exp_q);
    exp_q = '{'h011, 'h122, 'h033, 'h144};
    check_log("alt_rsp", rsp_q, exp_q);

    // Single requester, three words.
    clear_logs();
    send_txn(0, 32'h00813CA5, 3, 0);
    wait_release();
    exp_q = '{'h0A5, 'h03C, 'h081};
    check_log("r0_rsp", rsp_q, exp_q);
    check("cs0_went_low", cs0_low != 0, 1'b1);
    check("cs1_low", cs1_low, 0);
    check("cs_idle", slave_cs_n, 2'b11);

    // Requester 1 arrives while requester 0 is mid-transaction.
    clear_logs();
    fork
      send_txn(0, 32'h00030201, 3, 0);
      begin
        repeat (3) @(negedge clk);
        send_txn(1, 32'h44, 1, 0);
      end
    join
    wait_release();
    exp_q = '{1, 2};
    check_log("mid_grant", gnt_q, exp_q);
    exp_q = '{'h001, 'h002, 'h003, 'h144};
    check_log("mid_rsp", rsp_q, exp_q);
    check("dr1_after_rsp", first_dr1, 3);
    check("mid_viol", viol, 0);

    // Single-word transaction and its FSM path.
    clear_logs();
    send_txn(0, 32'hFF, 1, 0);
    wait_release();
    exp_q = '{'h0FF};
    check_log("one_rsp", rsp_q, exp_q);
    exp_q = '{1, 2, 3, 0};
    check_log("one_path", st_q, exp_q);

    // Reset during the second of four words (rr_ptr is 1 here).
    clear_logs();
    req_d[7:0] = 8'h10;
    req_dv[0] = 1'b1;
    wait_dr(0);
    @(negedge clk);
    req_d[7:0] = 8'h20;
    wait_dr(0);
    @(negedge clk);
    req_d[7:0] = 8'h30;
    rst = 1'b1;
    @(negedge clk);
    check("mrst_grant", grant, 2'b00);
    check("mrst_cs", slave_cs_n, 2'b11);
    check("mrst_m_dv", m_spi_dv, 1'b0);
    req_dv = '0;
    req_last = '0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    clear_logs();
    fork
      send_txn(0, 32'h55, 1, 0);
      send_txn(1, 32'h66, 1, 0);
    join
    wait_release();
    exp_q = '{1, 2};
    check_log("post_rst_grant", gnt_q, exp_q);
    exp_q = '{'h055, 'h166};
    check_log("post_rst_rsp", rsp_q, exp_q);

    // Requester 0 pauses 40 cycles between words; 1 waits.
    clear_logs();
    fork
      send_txn(0, 32'h7271, 2, 40);
      begin
        repeat (5) @(negedge clk);
        send_txn(1, 32'h99, 1, 0);
      end
    join
    wait_release();
    exp_q = '{1, 2};
    check_log("gap_grant", gnt_q, exp_q);
    exp_q = '{'h071, 'h072, 'h199};
    check_log("gap_rsp", rsp_q, exp_q);
    check("gap_viol", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
